// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

  // Controller state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default operand width of the multiplier.
  localparam int MUL_W_DEFAULT = 32;

  // Widest operand the negate helper handles; callers zero-extend into it
  // and keep only their low W bits, which is exact for two's complement.
  localparam int MUL_MAX_W = 128;

  // Conditional two's-complement negate (returns v when en is low).
  function automatic logic [MUL_MAX_W-1:0] cond_neg(
    input logic [MUL_MAX_W-1:0] v,
    input logic                 en
  );
    return en ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl.sv
// Control path of mul_seq: FSM, iteration counter, start acceptance and
// busy/done decode. Optional macro MUL_SEQ_EARLY_EXIT_EN ends the run as
// soon as the remaining multiplier bits are all zero.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int W  = MUL_W_DEFAULT,
  parameter int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
`ifdef MUL_SEQ_EARLY_EXIT_EN
  input  logic [W-1:0]  mplier_next,
`endif
  output logic          busy,
  output logic          done,
  output logic          accept,
  output logic          last,
  output logic [CW-1:0] cnt
);

  state_t state_q, state_d;
  logic   final_iter;

`ifdef MUL_SEQ_EARLY_EXIT_EN
  assign final_iter = (cnt == CW'(W - 1)) || (mplier_next == '0);
`else
  assign final_iter = (cnt == CW'(W - 1));
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge values, independent of block ordering.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and output decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (final_iter) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Iteration counter: cleared on acceptance, advances once per RUN edge.
  always_ff @(posedge clk) begin
    if (rst)                 cnt <= '0;
    else if (accept)         cnt <= '0;
    else if (state_q == RUN) cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier, W x W -> 2W, one multiplier bit per
// clock, LSB first, with start/busy/done handshake and signed mode.
// Optional macro MUL_SEQ_EARLY_EXIT_EN finishes once the remaining
// multiplier bits are zero; without it latency is always W cycles.
module mul_seq
  import mul_pkg::*;
#(
  parameter int W  = MUL_W_DEFAULT,
  parameter int CW = $clog2(W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sgn,
  input  logic [W-1:0]   op1,
  input  logic [W-1:0]   op2,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] res
);

  localparam int PW = 2 * W;

  logic [W-1:0]  mcand_q, mplier_q, mplier_next;
  logic [W-1:0]  mag1, mag2;
  logic          neg_q;
  logic          accept, last;
  logic [CW-1:0] cnt;
  logic [PW-1:0] acc_q, acc_next, addend, res_q;

  // Operand magnitudes; only negative signed operands are negated, so the
  // most negative value maps to 2^(W-1), which still fits in W bits.
  assign mag1 = W'(cond_neg(MUL_MAX_W'(op1), sgn & op1[W-1]));
  assign mag2 = W'(cond_neg(MUL_MAX_W'(op2), sgn & op2[W-1]));

  assign addend      = mplier_q[0] ? (PW'(mcand_q) << cnt) : '0;
  assign acc_next    = acc_q + addend;
  assign mplier_next = mplier_q >> 1;
  assign res         = res_q;

  mul_seq_ctrl #(
    .W  (W),
    .CW (CW)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef MUL_SEQ_EARLY_EXIT_EN
    .mplier_next (mplier_next),
`endif
    .busy        (busy),
    .done        (done),
    .accept      (accept),
    .last        (last),
    .cnt         (cnt)
  );

  // Datapath: capture on acceptance, accumulate while running, and write
  // the sign-corrected product on the final iteration.
  always_ff @(posedge clk) begin
    // NOTE: the data registers are reset as well so an aborted run leaves
    // a clean zero result rather than a stale partial product.
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      res_q    <= '0;
    end else if (accept) begin
      mcand_q  <= mag1;
      mplier_q <= mag2;
      neg_q    <= sgn & (op1[W-1] ^ op2[W-1]);
      acc_q    <= '0;
    end else if (busy) begin
      acc_q    <= acc_next;
      mplier_q <= mplier_next;
      if (last) res_q <= neg_q ? -acc_next : acc_next;
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed testbench for mul_seq at W=32 and W=8. Expected latency follows
// MUL_SEQ_EARLY_EXIT_EN when the bench is built with that macro.
module tb_mul_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start32, sgn32, busy32, done32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic        start8, sgn8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;

  int tests = 0;
  int fails = 0;

  mul_seq #(.W(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .sgn(sgn32), .op1(a32), .op2(b32),
    .busy(busy32), .done(done32), .res(res32)
  );

  mul_seq #(.W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .op1(a8), .op2(b8),
    .busy(busy8), .done(done8), .res(res8)
  );

  // Expected latency in cycles for a w-bit multiplier operand b.
  function automatic int exp_lat(input int w, input logic s, input logic [31:0] b);
    logic [31:0] mask, m;
    int l;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    m = b & mask;
    if (s && m[w-1]) m = (~m + 32'd1) & mask;
`ifdef MUL_SEQ_EARLY_EXIT_EN
    l = 1;
    for (int i = 0; i < w; i++) if (m[i]) l = i + 1;
`else
    l = w;
`endif
    return l;
  endfunction

  // Issue one W=32 operation (caller is 1 ns after a posedge) and wait for done.
  task automatic run32(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bc, output logic [63:0] r);
    start32 = 1'b1; sgn32 = s; a32 = a; b32 = b;
    @(posedge clk); #1;
    start32 = 1'b0;
    lat = -1; bc = 0; r = 'x;
    if (busy32) bc++;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done32) begin lat = k; r = res32; break; end
      if (busy32) bc++;
    end
  endtask

  // Issue one W=8 operation and wait for done.
  task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b,
                      output int lat, output int bc, output logic [15:0] r);
    start8 = 1'b1; sgn8 = s; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1; bc = 0; r = 'x;
    if (busy8) bc++;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done8) begin lat = k; r = res8; break; end
      if (busy8) bc++;
    end
  endtask

  task automatic test_reset();
    tests++; if (busy32 !== 1'b0)  begin fails++; $display("FAIL reset_busy32 got %b want 0", busy32); end
    tests++; if (done32 !== 1'b0)  begin fails++; $display("FAIL reset_done32 got %b want 0", done32); end
    tests++; if (res32 !== 64'h0)  begin fails++; $display("FAIL reset_res32 got %h want 0", res32); end
    tests++; if (busy8 !== 1'b0)   begin fails++; $display("FAIL reset_busy8 got %b want 0", busy8); end
    tests++; if (res8 !== 16'h0)   begin fails++; $display("FAIL reset_res8 got %h want 0", res8); end
  endtask

  task automatic test_unsigned_max();
    int lat, bc, el;
    logic [63:0] r;
    el = exp_lat(32, 1'b0, 32'hFFFF_FFFF);
    run32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, r);
    tests++; if (lat !== el) begin fails++; $display("FAIL umax_latency got %0d want %0d", lat, el); end
    tests++; if (bc !== el)  begin fails++; $display("FAIL umax_busy_cycles got %0d want %0d", bc, el); end
    tests++; if (r !== 64'hFFFF_FFFE_0000_0001)
      begin fails++; $display("FAIL umax_res got %h want fffffffe00000001", r); end
    @(posedge clk); #1;
    tests++; if (done32 !== 1'b0) begin fails++; $display("FAIL umax_done_one_cycle got %b want 0", done32); end
    tests++; if (res32 !== 64'hFFFF_FFFE_0000_0001)
      begin fails++; $display("FAIL umax_res_held got %h want fffffffe00000001", res32); end
  endtask

  typedef struct {
    logic        s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec8_t;

  task automatic test_modes8();
    vec8_t v[7];
    int lat, bc, el;
    logic [15:0] r;
    v[0] = '{1'b0, 8'h80, 8'h80, 16'h4000};
    v[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    v[2] = '{1'b1, 8'hFF, 8'h02, 16'hFFFE};
    v[3] = '{1'b0, 8'hFF, 8'h02, 16'h01FE};
    v[4] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
    v[5] = '{1'b1, 8'h00, 8'hFB, 16'h0000};
    v[6] = '{1'b1, 8'h7F, 8'h80, 16'hC080};
    foreach (v[i]) begin
      el = exp_lat(8, v[i].s, {24'h0, v[i].b});
      run8(v[i].s, v[i].a, v[i].b, lat, bc, r);
      tests++; if (r !== v[i].p)
        begin fails++; $display("FAIL mode8_res[%0d] got %h want %h", i, r, v[i].p); end
      tests++; if (lat !== el)
        begin fails++; $display("FAIL mode8_latency[%0d] got %0d want %0d", i, lat, el); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat, bc, el;
    logic [15:0] r;
    run8(1'b1, 8'h80, 8'h80, lat, bc, r);
    tests++; if (r !== 16'h4000) begin fails++; $display("FAIL b2b_first_res got %h want 4000", r); end
    // Still in the DONE cycle: issue the next operation.
    start8 = 1'b1; sgn8 = 1'b1; a8 = 8'hFD; b8 = 8'h05;
    @(posedge clk); #1;
    start8 = 1'b0;
    tests++; if (busy8 !== 1'b1) begin fails++; $display("FAIL b2b_busy got %b want 1", busy8); end
    tests++; if (done8 !== 1'b0) begin fails++; $display("FAIL b2b_done got %b want 0", done8); end
    tests++; if (res8 !== 16'h4000) begin fails++; $display("FAIL b2b_res_held got %h want 4000", res8); end
    el = exp_lat(8, 1'b1, 32'h05);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done8) begin lat = k; break; end
    end
    tests++; if (lat !== el) begin fails++; $display("FAIL b2b_latency got %0d want %0d", lat, el); end
    tests++; if (res8 !== 16'hFFF1) begin fails++; $display("FAIL b2b_res got %h want fff1", res8); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_held();
    int el, lat, extra;
    el = exp_lat(32, 1'b0, 32'd6);
    start32 = 1'b1; sgn32 = 1'b0; a32 = 32'd7; b32 = 32'd6;
    @(posedge clk); #1;
    lat = -1;
    for (int k = 0; k <= 100; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (done32) begin lat = k; break; end
      end
      // Keep start high and scramble operands while busy; drop start just
      // before the DONE cycle so no second operation is requested there.
      start32 = (k < el - 1);
      a32 = a32 + 32'd13; b32 = b32 ^ 32'h5A5A_0003; sgn32 = ~sgn32;
    end
    start32 = 1'b0;
    tests++; if (lat !== el) begin fails++; $display("FAIL held_latency got %0d want %0d", lat, el); end
    tests++; if (res32 !== 64'd42) begin fails++; $display("FAIL held_res got %0d want 42", res32); end
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (done32 || busy32) extra++;
    end
    tests++; if (extra !== 0) begin fails++; $display("FAIL held_no_second_op got %0d active cycles want 0", extra); end
  endtask

  task automatic test_abort();
    int lat, bc, el, seen;
    logic [63:0] r;
    start32 = 1'b1; sgn32 = 1'b0; a32 = 32'h0001_0000; b32 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if (busy32 !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy32); end
    tests++; if (done32 !== 1'b0) begin fails++; $display("FAIL abort_done got %b want 0", done32); end
    tests++; if (res32 !== 64'h0) begin fails++; $display("FAIL abort_res got %h want 0", res32); end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done32 || busy32) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL abort_no_done got %0d active cycles want 0", seen); end
    el = exp_lat(32, 1'b0, 32'd5);
    run32(1'b0, 32'd3, 32'd5, lat, bc, r);
    tests++; if (r !== 64'd15) begin fails++; $display("FAIL abort_restart_res got %0d want 15", r); end
    tests++; if (lat !== el) begin fails++; $display("FAIL abort_restart_latency got %0d want %0d", lat, el); end
  endtask

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec32_t;

  task automatic test_edges32();
    vec32_t v[5];
    int lat, bc, el;
    logic [63:0] r;
    v[0] = '{1'b0, 32'h0000_1234, 32'h0000_0001, 64'h1234};
    v[1] = '{1'b0, 32'h0000_1234, 32'h0000_0000, 64'h0};
    v[2] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFB, 64'h0};
    v[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    v[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000};
    foreach (v[i]) begin
      el = exp_lat(32, v[i].s, v[i].b);
      run32(v[i].s, v[i].a, v[i].b, lat, bc, r);
      tests++; if (r !== v[i].p)
        begin fails++; $display("FAIL edge32_res[%0d] got %h want %h", i, r, v[i].p); end
      tests++; if (lat !== el)
        begin fails++; $display("FAIL edge32_latency[%0d] got %0d want %0d", i, lat, el); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    start8  = 1'b0; sgn8  = 1'b0; a8  = '0; b8  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_unsigned_max();
    test_modes8();
    test_back_to_back();
    test_start_held();
    test_abort();
    test_edges32();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
